// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with ecall/unimp trap entry and mret return
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   csrtrapin_valid             MEM-stage instruction valid
//   csrtrapin_inst              MEM-stage instruction word
//   csrtrapin_pc                PC of that instruction
//   csrtrapin_rs1               rs1 operand value
//   csrtrapin_csr_write         CSR-update permission from CSR control
//   csrtrapin_mem_is_mret       mret flag from CSR control
//   csrtrapin_redirect_ready    fetch accepts the redirect
//   csrtrapout_rdata            pre-update value of the addressed CSR
//   csrtrapout_redirect_valid   redirect request pending
//   csrtrapout_redirect_pc      redirect target
//   csrtrapout_busy             upstream stall; inputs ignored while high
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] CAUSE_ECALL   = 32'd11,
    parameter logic [31:0] CAUSE_ILLEGAL = 32'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csrtrapin_valid,
    input  logic [31:0] csrtrapin_inst,
    input  logic [31:0] csrtrapin_pc,
    input  logic [31:0] csrtrapin_rs1,
    input  logic        csrtrapin_csr_write,
    input  logic        csrtrapin_mem_is_mret,
    input  logic        csrtrapin_redirect_ready,
    output logic [31:0] csrtrapout_rdata,
    output logic        csrtrapout_redirect_valid,
    output logic [31:0] csrtrapout_redirect_pc,
    output logic        csrtrapout_busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hc000_1073;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } state_t;

    state_t      r_state;
    logic        r_redirect_valid;
    logic        r_busy;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mie;
    logic        r_mpie;

    logic [2:0]  w_funct3;
    logic [11:0] w_addr;
    logic [4:0]  w_field;
    logic [6:0]  w_opcode;
    logic        w_is_ecall;
    logic        w_is_unimp;
    logic        w_is_trap;
    logic        w_is_csr;
    logic        w_accept;
    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_csr_we;

    assign w_funct3   = csrtrapin_inst[14:12];
    assign w_addr     = csrtrapin_inst[31:20];
    assign w_field    = csrtrapin_inst[19:15];
    assign w_opcode   = csrtrapin_inst[6:0];
    assign w_is_ecall = (csrtrapin_inst == INST_ECALL);
    assign w_is_unimp = (csrtrapin_inst == INST_UNIMP);
    assign w_is_trap  = w_is_ecall | w_is_unimp;
    // SYSTEM opcode with funct3 000 (priv) and 100 (reserved) is not a CSR op
    assign w_is_csr   = (w_opcode == 7'h73) && (w_funct3 != 3'b000) && (w_funct3 != 3'b100);
    assign w_accept   = csrtrapin_valid & ~r_busy & (csrtrapin_csr_write | csrtrapin_mem_is_mret);
    assign w_mstatus  = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};

    always_comb begin
        w_old = 32'b0;
        case (w_addr)
            ADDR_MTVEC:   w_old = r_mtvec;
            ADDR_MEPC:    w_old = r_mepc;
            ADDR_MSTATUS: w_old = w_mstatus;
            ADDR_MCAUSE:  w_old = r_mcause;
            default:      w_old = 32'b0;
        endcase
    end

    assign csrtrapout_rdata = w_is_csr ? w_old : 32'b0;

    // funct3[2] selects the immediate form; [1:0] selects RW/RS/RC
    assign w_src = w_funct3[2] ? {27'b0, w_field} : csrtrapin_rs1;

    always_comb begin
        w_new = w_old;
        case (w_funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // Set/clear with a zero source field are pure reads; trap/mret decode wins over CSR write
    assign w_csr_we = w_accept & w_is_csr & ~w_is_trap & ~csrtrapin_mem_is_mret &
                      ((w_funct3[1:0] == 2'b01) || (w_field != 5'd0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_redirect_pc    <= 32'b0;
            r_mtvec          <= MTVEC_RESET;
            r_mepc           <= 32'b0;
            r_mcause         <= 32'b0;
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_trap) begin
                        r_mepc           <= csrtrapin_pc & ~32'h3;
                        r_mcause         <= w_is_ecall ? CAUSE_ECALL : CAUSE_ILLEGAL;
                        r_mpie           <= r_mie;
                        r_mie            <= 1'b0;
                        r_redirect_pc    <= r_mtvec;
                        r_redirect_valid <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= ST_REDIRECT;
                    end else if (w_accept && csrtrapin_mem_is_mret) begin
                        r_mie            <= r_mpie;
                        r_mpie           <= 1'b1;
                        r_redirect_pc    <= r_mepc;
                        r_redirect_valid <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= ST_REDIRECT;
                    end else if (w_csr_we) begin
                        case (w_addr)
                            ADDR_MTVEC:   r_mtvec <= w_new & ~32'h3;
                            ADDR_MEPC:    r_mepc  <= w_new & ~32'h3;
                            ADDR_MSTATUS: begin
                                r_mie  <= w_new[3];
                                r_mpie <= w_new[7];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REDIRECT: begin
                    if (csrtrapin_redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                        r_state          <= ST_IDLE;
                    end
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_busy           <= 1'b0;
                    r_state          <= ST_IDLE;
                end
            endcase
        end
    end

    assign csrtrapout_redirect_valid = r_redirect_valid;
    assign csrtrapout_redirect_pc    = r_redirect_pc;
    assign csrtrapout_busy           = r_busy;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - scoreboard bench for csr_trap_unit with reference model
module tb_csr_trap_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] UNIMP     = 32'hc000_1073;
    localparam logic [31:0] MRET      = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] inst = 32'b0;
    logic [31:0] pc = 32'b0;
    logic [31:0] rs1 = 32'b0;
    logic        csr_write = 1'b0;
    logic        is_mret = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    csr_trap_unit #(
        .MTVEC_RESET  (MTVEC_RST),
        .CAUSE_ECALL  (32'd11),
        .CAUSE_ILLEGAL(32'd2)
    ) dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .csrtrapin_valid          (valid),
        .csrtrapin_inst           (inst),
        .csrtrapin_pc             (pc),
        .csrtrapin_rs1            (rs1),
        .csrtrapin_csr_write      (csr_write),
        .csrtrapin_mem_is_mret    (is_mret),
        .csrtrapin_redirect_ready (ready),
        .csrtrapout_rdata         (rdata),
        .csrtrapout_redirect_valid(redirect_valid),
        .csrtrapout_redirect_pc   (redirect_pc),
        .csrtrapout_busy          (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_rdata[$];
    logic [31:0] q_redir[$];

    // Reference machine state
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    bit          m_mie;
    bit          m_mpie;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mstatus();
        return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] w);
        logic [2:0]  f3;
        logic [11:0] a;
        f3 = w[14:12];
        a  = w[31:20];
        if (w[6:0] != 7'h73 || f3 == 3'd0 || f3 == 3'd4) return 32'b0;
        case (a)
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h300: return model_mstatus();
            12'h342: return m_mcause;
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtvec  = MTVEC_RST;
        m_mepc   = 32'b0;
        m_mcause = 32'b0;
        m_mie    = 1'b0;
        m_mpie   = 1'b0;
    endtask

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] fld);
        return {a, fld, f3, 5'd0, 7'h73};
    endfunction

    // Called at posedge+1 with the DUT idle; drives one instruction for one cycle
    task automatic issue(input logic [31:0] w, input logic [31:0] p, input logic [31:0] r,
                         input logic cw, input logic mr);
        logic [31:0] old_v;
        logic [31:0] src;
        logic [31:0] nv;
        logic [2:0]  f3;
        inst = w; pc = p; rs1 = r; csr_write = cw; is_mret = mr; valid = 1'b1;
        old_v = model_read(w);
        q_rdata.push_back(old_v);
        f3 = w[14:12];
        if (cw || mr) begin
            if (w == ECALL || w == UNIMP) begin
                q_redir.push_back(m_mtvec);
                m_mepc   = p & ~32'h3;
                m_mcause = (w == ECALL) ? 32'd11 : 32'd2;
                m_mpie   = m_mie;
                m_mie    = 1'b0;
            end else if (mr) begin
                q_redir.push_back(m_mepc);
                m_mie  = m_mpie;
                m_mpie = 1'b1;
            end else if (w[6:0] == 7'h73 && f3 != 3'd0 && f3 != 3'd4) begin
                src = f3[2] ? 32'(w[19:15]) : r;
                if (f3[1:0] == 2'b01 || w[19:15] != 5'd0) begin
                    if (f3[1:0] == 2'b01)      nv = src;
                    else if (f3[1:0] == 2'b10) nv = old_v | src;
                    else                       nv = old_v & ~src;
                    case (w[31:20])
                        12'h305: m_mtvec = nv & ~32'h3;
                        12'h341: m_mepc  = nv & ~32'h3;
                        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                        default: ;
                    endcase
                end
            end
        end
        @(posedge clk); #1;
        valid = 1'b0; inst = 32'b0; csr_write = 1'b0; is_mret = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n;
        n = 0;
        while (busy && n < 50) begin
            ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("return_idle", {31'b0, busy}, 32'b0);
        ready = 1'($urandom % 2);
    endtask

    task automatic read_csr(input logic [11:0] a);
        issue(csr_inst(a, 3'b010, 5'd0), 32'h0, 32'hffff_ffff, 1'b1, 1'b0);
    endtask

    // Monitor: compares outputs against the scoreboard queues
    bit          prev_rv = 1'b0;
    logic [31:0] held_pc = 32'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_rv = 1'b0;
        end else begin
            check("busy_eq_redirect_valid", {31'b0, busy}, {31'b0, redirect_valid});
            if (valid && !busy) begin
                if (q_rdata.size() == 0) check("rdata_unexpected", {31'b0, valid}, 32'b0);
                else check("rdata", rdata, q_rdata.pop_front());
            end
            if (redirect_valid && !prev_rv) begin
                if (q_redir.size() == 0) check("redirect_unexpected", {31'b0, redirect_valid}, 32'b0);
                else check("redirect_pc", redirect_pc, q_redir.pop_front());
            end else if (redirect_valid && prev_rv) begin
                check("redirect_pc_stable", redirect_pc, held_pc);
            end
            prev_rv = redirect_valid;
            held_pc = redirect_pc;
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'b0);
        check("rst_busy", {31'b0, busy}, 32'b0);
        check("rst_redirect_pc", redirect_pc, 32'b0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        read_csr(12'h305); read_csr(12'h341); read_csr(12'h300); read_csr(12'h342);

        // csrrw x0, mtvec, rs1 = 0x8000_0103 -> low bits dropped
        issue(csr_inst(12'h305, 3'b001, 5'd1), 32'h0, 32'h8000_0103, 1'b1, 1'b0);
        read_csr(12'h305);

        // ecall with MIE set and mtvec 0x100, redirect held 3 cycles
        issue(csr_inst(12'h305, 3'b001, 5'd1), 32'h0, 32'h0000_0100, 1'b1, 1'b0);
        issue(csr_inst(12'h300, 3'b110, 5'd8), 32'h0, 32'h0, 1'b1, 1'b0);
        ready = 1'b0;
        issue(ECALL, 32'h40, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("hold_busy", {31'b0, busy}, 32'h1);
            check("hold_redirect_valid", {31'b0, redirect_valid}, 32'h1);
            check("hold_redirect_pc", redirect_pc, 32'h100);
            @(posedge clk); #1;
        end
        ready = 1'b1;
        @(posedge clk); #1;
        check("release_busy", {31'b0, busy}, 32'b0);
        ready = 1'b0;
        read_csr(12'h341); read_csr(12'h342); read_csr(12'h300);

        // mcause is read-only to CSR instructions
        issue(csr_inst(12'h342, 3'b001, 5'd2), 32'h0, 32'h1234_5678, 1'b1, 1'b0);
        read_csr(12'h342);

        // mret from mepc 0x44 with mstatus 0x80
        issue(csr_inst(12'h341, 3'b001, 5'd1), 32'h0, 32'h44, 1'b1, 1'b0);
        issue(MRET, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle(1'b1);
        read_csr(12'h300);

        // unimp at 0x200, then csrrs with rs1 field 0 on mstatus
        issue(UNIMP, 32'h200, 32'h0, 1'b1, 1'b0);
        wait_idle(1'b1);
        read_csr(12'h342); read_csr(12'h341);
        issue(csr_inst(12'h300, 3'b010, 5'd0), 32'h0, 32'hffff_ffff, 1'b1, 1'b0);
        read_csr(12'h300);

        // redirect_ready high in IDLE and unpermitted instruction both do nothing
        ready = 1'b1;
        issue(ECALL, 32'h80, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("idle_ready_no_redirect", {31'b0, redirect_valid}, 32'b0);
        ready = 1'b0;

        // Reset during REDIRECT aborts it
        issue(ECALL, 32'h300, 32'h0, 1'b1, 1'b0);
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rst_abort_redirect_valid", {31'b0, redirect_valid}, 32'b0);
        check("rst_abort_busy", {31'b0, busy}, 32'b0);
        check("rst_abort_redirect_pc", redirect_pc, 32'b0);
        model_reset();
        @(negedge clk); rstn = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_redirect_after_reset", {31'b0, redirect_valid}, 32'b0);
        read_csr(12'h305); read_csr(12'h341); read_csr(12'h300); read_csr(12'h342);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [11:0] addrs[5];
            logic [2:0]  f3s[6];
            int          k;
            logic [31:0] w;
            logic        cw;
            logic        mr;
            logic [4:0]  fld;
            addrs = '{12'h305, 12'h341, 12'h300, 12'h342, 12'h344};
            f3s   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
            k  = int'($urandom % 10);
            cw = ($urandom % 8) != 0;
            mr = 1'b0;
            fld = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            if (k <= 5)      w = csr_inst(addrs[$urandom % 5], f3s[$urandom % 6], fld);
            else if (k == 6) w = ECALL;
            else if (k == 7) w = UNIMP;
            else if (k == 8) begin w = MRET; mr = ($urandom % 8) != 0; end
            else             w = {$urandom} & 32'hffff_ff80 | 32'h33;
            issue(w, $urandom & ~32'h3, $urandom, cw, mr);
            wait_idle(1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rdata_queue_empty", 32'(q_rdata.size()), 32'b0);
        check("redirect_queue_empty", 32'(q_redir.size()), 32'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
